data_mem_access: RTL
====================

// Module: data_mem_access
// PURPOSE
//   Load/store stage directly downstream of the ALU: takes the ALU result as the effective address
//   and drives a req/ack word-wide data-memory bus. Handles byte/half/word lanes, load sign/zero
//   extension, a bus timeout and a stall to the core while an access is in flight.
// PARAMETERS
//   TIMEOUT_CYCLES  16  cycles in REQ without busAck before a bus error is raised (>=1)
// PORTS
//   CLK        in   1   clock, rising edge
//   Reset      in   1   synchronous, active-high
//   ctrlValid  in   1   instruction in this stage is valid
//   memRead    in   1   load request (memRead & memWrite both 1: treated as write)
//   memWrite   in   1   store request
//   memSize    in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//   memSigned  in   1   1 = sign-extend loaded byte/half, 0 = zero-extend
//   aluResult  in   32  effective byte address from ALU
//   storeData  in   32  rt value; low bits used for byte/half stores
//   stall      out  1   combinational; hold PC and pipeline state while 1
//   loadData   out  32  extended load result, valid while loadValid
//   loadValid  out  1   one-cycle pulse when loadData is valid
//   busErr     out  1   one-cycle pulse on timeout
//   misaligned out  1   one-cycle pulse on misaligned access (see CONFIGURATION)
//   busReq     out  1   bus request, held until busAck
//   busWe      out  1   1 = write
//   busAddr    out  32  word-aligned address, busAddr[1:0] = 00
//   busByteEn  out  4   lane enables, bit i = bits [8i+7:8i], little-endian
//   busWData   out  32  write data, lanes replicated
//   busRData   in   32  read data, sampled on the busAck cycle
//   busAck     in   1   one-cycle completion strobe from memory
// BEHAVIOUR
//   - FSM IDLE -> REQ -> DONE -> IDLE; REQ -> ERR -> IDLE on timeout.
//   - IDLE: on ctrlValid & (memRead|memWrite) & access legal, register addr/lanes/data/we.
//     Next cycle is REQ. stall = 1 combinationally in this same cycle.
//   - REQ: busReq = 1; bus outputs stay stable until busAck; stall = 1.
//     On busAck: latch busRData, go to DONE. A busAck outside REQ is ignored.
//   - DONE: stall = 0; loadValid = 1 for reads; go to IDLE. The core advances on this edge.
//     Minimum access latency: 2 cycles, with busAck arriving in the first REQ cycle.
//   - ERR: entered when the timeout counter reaches TIMEOUT_CYCLES-1 in REQ without busAck.
//     busErr = 1, stall = 0, loadData = 0, busReq dropped; go to IDLE.
//     busAck arriving on the same cycle as the timeout wins (go to DONE).
//   - Lanes: byte: busByteEn = 1 << a[1:0], busWData = {4{sd[7:0]}}.
//     Half: busByteEn = a[1] ? 1100 : 0011, busWData = {2{sd[15:0]}}. Word: 1111, sd.
//   - Load: shift busRData right by 8*a[1:0], then extend 8/16 bits per memSigned. Word is unchanged.
//   - Reset: all outputs 0 on the edge after Reset is seen. busReq drops mid-access, counter clears,
//     state goes to IDLE. While Reset = 1, stall = 0.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined:
//     half with a[0] = 1, or word with a[1:0] != 00, makes no bus access.
//     misaligned pulses 1 for the IDLE cycle; stall = 0; loadData = 0.
//   MISALIGN_TRAP_EN undefined:
//     low address bits are ignored (half uses a[1], word uses 00); misaligned is tied to 0.
// STRUCTURE
//   Package data_mem_access_pkg holds:
//     state enum {IDLE, REQ, DONE, ERR};
//     size constants SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10;
//     function lane_en(size, addr).
//   One sub-module, load_align: combinational busRData + offset + size + signed -> loadData.
// TESTING
//   - lb signed: a = 0x1003, rdata = 0x80FF_1234, ack in 1st REQ cycle
//       -> byteEn 1000, loadData 0xFFFF_FF80, loadValid 1 cycle, stall 2 cycles.
//   - sh: a = 0x2002, sd = 0x0000_ABCD, ack after 3 cycles
//       -> busWe 1, byteEn 1100, wdata 0xABCD_ABCD, busReq stable 4 cycles.
//   - lhu: a = 0x10, rdata = 0x1234_8001 -> loadData 0x0000_8001.
//   - timeout: TIMEOUT_CYCLES = 4, no ack -> busErr pulse after 4 REQ cycles, busReq 0, stall 0.
//   - misaligned lw a = 0x6: with MISALIGN_TRAP_EN -> misaligned = 1, busReq never 1;
//     without it -> busAddr 0x4, byteEn 1111.
//   - Reset asserted in 2nd REQ cycle -> next edge busReq 0, state IDLE; a late ack is ignored.

Source files
------------

// File: rtl/data_mem_access_pkg.sv
// Shared types and helpers for the data-memory load/store stage.
package data_mem_access_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} stateT;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [LANES-1:0]  byteEn;
        logic [DATA_W-1:0] wData;
    } busCmdT;

    // Byte-lane enables for an access; reserved size behaves as a word.
    function automatic logic [LANES-1:0] lane_en(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SIZE_B:  lane_en = 4'b0001 << addr;
            SIZE_H:  lane_en = addr[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_access_if.sv
// Word-wide req/ack data-memory bus between the load/store stage and memory.
interface data_mem_access_if;
    import data_mem_access_pkg::*;

    logic              busReq;
    logic              busWe;
    logic [DATA_W-1:0] busAddr;
    logic [LANES-1:0]  busByteEn;
    logic [DATA_W-1:0] busWData;
    logic [DATA_W-1:0] busRData;
    logic              busAck;

    modport master (output busReq, busWe, busAddr, busByteEn, busWData,
                    input  busRData, busAck);
    modport slave  (input  busReq, busWe, busAddr, busByteEn, busWData,
                    output busRData, busAck);
endinterface

// File: rtl/data_mem_access_load_align.sv
// Combinational load alignment: lane shift plus byte/half sign or zero extension.
module load_align
    import data_mem_access_pkg::*;
(
    input  logic [DATA_W-1:0] rData,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              isSigned,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;

    assign shifted = rData >> {offset, 3'b000};

    always_comb begin
        data = shifted;
        case (size)
            SIZE_B:  data = {{24{isSigned & shifted[7]}},  shifted[7:0]};
            SIZE_H:  data = {{16{isSigned & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_access.sv
// Load/store stage driving a req/ack data-memory bus with timeout and core stall.
// Optional MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of ignoring low address bits.
module data_mem_access
    import data_mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
(
    input  logic              CLK,
    input  logic              Reset,
    input  logic              ctrlValid,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [1:0]        memSize,
    input  logic              memSigned,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] storeData,
    output logic              stall,
    output logic [DATA_W-1:0] loadData,
    output logic              loadValid,
    output logic              busErr,
    output logic              misaligned,
    data_mem_access_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    stateT             state;
    busCmdT            cmd;
    logic              busReqQ;
    logic              misalignedQ;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        sizeQ;
    logic              signedQ;
    logic [1:0]        offQ;

    logic              request;
    logic              badAlign;
    logic              accept;
    logic [1:0]        effOff;
    logic [DATA_W-1:0] wDataNext;
    logic [DATA_W-1:0] alignedData;

    assign request = ctrlValid & (memRead | memWrite);

`ifdef MISALIGN_TRAP_EN
    assign badAlign = ((memSize == SIZE_H) & aluResult[0]) |
                      ((memSize[1] == 1'b1) & (aluResult[1:0] != 2'b00));
`else
    assign badAlign = 1'b0;
`endif

    assign accept = (state == IDLE) & request & ~badAlign;
    assign stall  = ~Reset & (accept | (state == REQ));

    // Effective lane offset once ignored low address bits are dropped.
    always_comb begin
        effOff    = 2'b00;
        wDataNext = storeData;
        case (memSize)
            SIZE_B: begin
                effOff    = aluResult[1:0];
                wDataNext = {4{storeData[7:0]}};
            end
            SIZE_H: begin
                effOff    = {aluResult[1], 1'b0};
                wDataNext = {2{storeData[15:0]}};
            end
            default: begin
                effOff    = 2'b00;
                wDataNext = storeData;
            end
        endcase
    end

    load_align u_loadAlign (
        .rData    (bus.busRData),
        .offset   (offQ),
        .size     (sizeQ),
        .isSigned (signedQ),
        .data     (alignedData)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= IDLE;
            cmd         <= '0;
            busReqQ     <= 1'b0;
            misalignedQ <= 1'b0;
            cnt         <= '0;
            sizeQ       <= SIZE_B;
            signedQ     <= 1'b0;
            offQ        <= 2'b00;
            loadData    <= '0;
            loadValid   <= 1'b0;
            busErr      <= 1'b0;
        end else begin
            loadValid   <= 1'b0;
            busErr      <= 1'b0;
            misalignedQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd.we     <= memWrite;
                        cmd.addr   <= {aluResult[DATA_W-1:2], 2'b00};
                        cmd.byteEn <= lane_en(memSize, effOff);
                        cmd.wData  <= wDataNext;
                        sizeQ      <= memSize;
                        signedQ    <= memSigned;
                        offQ       <= effOff;
                        cnt        <= '0;
                        busReqQ    <= 1'b1;
                        state      <= REQ;
                    end else if (request & badAlign) begin
                        misalignedQ <= 1'b1;
                        loadData    <= '0;
                    end
                end
                REQ: begin
                    // A same-cycle ack takes priority over the timeout.
                    if (bus.busAck) begin
                        busReqQ   <= 1'b0;
                        loadValid <= ~cmd.we;
                        if (!cmd.we) begin
                            loadData <= alignedData;
                        end
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        busReqQ  <= 1'b0;
                        busErr   <= 1'b1;
                        loadData <= '0;
                        state    <= ERR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign misaligned    = misalignedQ;
    assign bus.busReq    = busReqQ;
    assign bus.busWe     = cmd.we;
    assign bus.busAddr   = cmd.addr;
    assign bus.busByteEn = cmd.byteEn;
    assign bus.busWData  = cmd.wData;

endmodule
